sr_latch_driver: RTL and testbench
==================================

Name: sr_latch_driver

Overview:
- Synchronous initiator for a cross-coupled SR latch; converts single-cycle set/clear commands into clean, non-overlapping s/r pulses.
- Guarantees s and r are never asserted together, so the latch never sees the forbidden s=1,r=1 input.
- Reads back the latch's q/q_bar through a synchronizer and reports pass/fault per command.
- Sits between control logic and the latch; it is the driving end of the latch's s/r interface.

Parameters:
- PULSE_CYC, 2, cycles s or r is held high per command (>=1)
- GUARD_CYC, 1, cycles s=r=0 after the pulse before settling starts (>=1)
- SETTLE_CYC, 2, cycles waited for synchronized feedback before compare (>=2, covers the 2-flop sync)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- set_req  input  1  command valid: drive latch to 1
- clr_req  input  1  command valid: drive latch to 0
- cmd_ready  output  1  high when a command can be accepted
- s  output  1  latch set input, registered
- r  output  1  latch reset input, registered
- q_fb  input  1  latch q, asynchronous to clk
- q_bar_fb  input  1  latch q_bar, asynchronous to clk
- done  output  1  one-cycle pulse: command finished, result valid
- fault  output  1  valid with done: readback mismatch
- illegal  output  1  one-cycle pulse: set_req and clr_req both high while ready
- state_q  output  1  last successfully verified latch value

Behaviour:
- Reset (async, rst_n=0): s=0, r=0, done=0, fault=0, illegal=0, state_q=0, cmd_ready=1, FSM=IDLE, sync flops=0. Asserting reset mid-pulse drops s/r immediately; no done is produced.
- FSM states: IDLE -> PULSE -> GUARD -> SETTLE -> IDLE.
- IDLE:
  - cmd_ready=1.
  - At a rising edge with exactly one of set_req/clr_req high: latch target (1 for set, 0 for clear) and go to PULSE.
  - With both high: stay in IDLE, assert illegal for the next cycle, leave s/r at 0.
  - With neither high: no action.
- PULSE: cmd_ready=0; s=target, r=~target, held for exactly PULSE_CYC cycles.
- GUARD: s=0, r=0 for GUARD_CYC cycles. s/r change only via this state, so s and r are never both 1, not even for one cycle.
- SETTLE: s=r=0 for SETTLE_CYC cycles. On the last SETTLE cycle, compare the synchronized feedback: pass iff q_sync==target and q_bar_sync==~target.
- Return to IDLE:
  - done=1 for one cycle; fault=~pass on the same cycle, 0 otherwise.
  - On pass, state_q<=target; on fault, state_q is unchanged.
  - cmd_ready=1 in the done cycle, so back-to-back commands are accepted there.
- Timing with defaults (accept at edge 0): s or r high in cycles 1-2, guard cycle 3, settle cycles 4-5, done/fault in cycle 6. Latency = PULSE_CYC+GUARD_CYC+SETTLE_CYC+1.
- Requests while cmd_ready=0 are ignored, not queued.
- Feedback: 2-flop synchronizer on each of q_fb and q_bar_fb. q_fb==q_bar_fb at compare time is a fault.
- Counters are sized clog2(max param)+1 and reload on every state entry.

Decomposition:
- Shared package sr_drv_pkg holds:
  - FSM state encoding (IDLE, PULSE, GUARD, SETTLE)
  - target encodings
  - counter-width localparam
- One sub-module, sr_fb_sync: a 2-flop synchronizer with async active-low reset, instantiated once per feedback bit.

Test Plan:
- Set with behavioral latch model attached: set_req=1 for 1 cycle from reset -> s=1 in cycles 1-2, r=0 throughout, done=1, fault=0 in cycle 6, state_q=1.
- Clear after set: clr_req pulse -> r=1 for 2 cycles, s=0 throughout, done in cycle 6, state_q=0, fault=0.
- Conflict: set_req=clr_req=1 in IDLE -> illegal=1 for one cycle, s=r=0, cmd_ready stays 1, no done.
- Stuck latch (q_fb forced 0): set command -> done=1, fault=1, state_q stays 0. Then q_fb=q_bar_fb=1 on a clear command -> fault=1.
- Back-to-back: a new set_req in the done cycle is accepted; a request issued mid-PULSE is ignored. Assertion: s&r never 1 over 1000 random commands.
- Reset mid-operation: rst_n=0 during PULSE -> s=r=0 without waiting for a clock edge, cmd_ready=1, no done; after release, the next command runs normally.

Source files
------------

// File: rtl/sr_drv_pkg.sv
// rtl/sr_drv_pkg.sv - shared encodings and sizing helpers for the SR latch driver
package sr_drv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_GUARD  = 2'd2,
    ST_SETTLE = 2'd3
  } sr_state_e;

  typedef enum logic {
    TGT_CLR = 1'b0,
    TGT_SET = 1'b1
  } sr_tgt_e;

  localparam int PULSE_CYC_DEF  = 2;
  localparam int GUARD_CYC_DEF  = 1;
  localparam int SETTLE_CYC_DEF = 2;

  // Width of the shared phase counter: enough for the longest phase, plus one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sr_fb_sync.sv
// rtl/sr_fb_sync.sv - two-flop synchronizer for one latch feedback bit
module sr_fb_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/sr_latch_driver.sv
// rtl/sr_latch_driver.sv - drives non-overlapping s/r pulses into an SR latch and verifies readback
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_CYC  = PULSE_CYC_DEF,
  parameter int GUARD_CYC  = GUARD_CYC_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic clr_req,
  output logic cmd_ready,
  output logic s,
  output logic r,
  input  logic q_fb,
  input  logic q_bar_fb,
  output logic done,
  output logic fault,
  output logic illegal,
  output logic state_q
);

  localparam int CW = cnt_width(PULSE_CYC, GUARD_CYC, SETTLE_CYC);

  localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] GUARD_LD  = CW'(GUARD_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);

  sr_state_e       r_state;
  sr_tgt_e         r_tgt;
  logic [CW-1:0]   r_cnt;
  logic            r_s;
  logic            r_r;
  logic            r_done;
  logic            r_fault;
  logic            r_illegal;
  logic            r_state_q;

  sr_state_e       w_state_nxt;
  sr_tgt_e         w_tgt_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_s_nxt;
  logic            w_r_nxt;
  logic            w_done_nxt;
  logic            w_fault_nxt;
  logic            w_illegal_nxt;
  logic            w_state_q_nxt;

  logic            w_q_sync;
  logic            w_qb_sync;
  logic            w_cnt_zero;
  logic            w_tgt_bit;
  logic            w_pass;

  sr_fb_sync u_sync_q (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (q_fb),
    .o_q   (w_q_sync)
  );

  sr_fb_sync u_sync_qb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (q_bar_fb),
    .o_q   (w_qb_sync)
  );

  assign w_cnt_zero = (r_cnt == '0);
  assign w_tgt_bit  = (r_tgt == TGT_SET);
  // Equal q/q_bar can never match target/~target, so it falls out as a fault.
  assign w_pass     = (w_q_sync == w_tgt_bit) && (w_qb_sync == ~w_tgt_bit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_tgt   <= TGT_CLR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tgt   <= w_tgt_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tgt_nxt     = r_tgt;
    w_cnt_nxt     = r_cnt;
    w_s_nxt       = 1'b0;
    w_r_nxt       = 1'b0;
    w_done_nxt    = 1'b0;
    w_fault_nxt   = 1'b0;
    w_illegal_nxt = 1'b0;
    w_state_q_nxt = r_state_q;

    unique case (r_state)
      ST_IDLE: begin
        if (set_req ^ clr_req) begin
          w_tgt_nxt   = set_req ? TGT_SET : TGT_CLR;
          w_state_nxt = ST_PULSE;
          w_cnt_nxt   = PULSE_LD;
          w_s_nxt     = set_req;
          w_r_nxt     = clr_req;
        end else if (set_req && clr_req) begin
          w_illegal_nxt = 1'b1;
        end
      end

      ST_PULSE: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_GUARD;
          w_cnt_nxt   = GUARD_LD;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
          w_s_nxt   = w_tgt_bit;
          w_r_nxt   = ~w_tgt_bit;
        end
      end

      ST_GUARD: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = SETTLE_LD;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end

      ST_SETTLE: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
          w_fault_nxt = ~w_pass;
          if (w_pass) begin
            w_state_q_nxt = w_tgt_bit;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // s/r are registered so the latch never sees combinational glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s       <= 1'b0;
      r_r       <= 1'b0;
      r_done    <= 1'b0;
      r_fault   <= 1'b0;
      r_illegal <= 1'b0;
      r_state_q <= 1'b0;
    end else begin
      r_s       <= w_s_nxt;
      r_r       <= w_r_nxt;
      r_done    <= w_done_nxt;
      r_fault   <= w_fault_nxt;
      r_illegal <= w_illegal_nxt;
      r_state_q <= w_state_q_nxt;
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign s         = r_s;
  assign r         = r_r;
  assign done      = r_done;
  assign fault     = r_fault;
  assign illegal   = r_illegal;
  assign state_q   = r_state_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb/tb_sr_latch_driver.sv - directed self-checking bench for sr_latch_driver
module tb_sr_latch_driver;

  logic clk;
  logic rst_n;
  logic set_req;
  logic clr_req;
  logic cmd_ready;
  logic s;
  logic r;
  logic q_fb;
  logic q_bar_fb;
  logic done;
  logic fault;
  logic illegal;
  logic state_q;

  logic     lq;
  int       fb_mode;
  int       total;
  int       bad;

  sr_latch_driver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_req   (set_req),
    .clr_req   (clr_req),
    .cmd_ready (cmd_ready),
    .s         (s),
    .r         (r),
    .q_fb      (q_fb),
    .q_bar_fb  (q_bar_fb),
    .done      (done),
    .fault     (fault),
    .illegal   (illegal),
    .state_q   (state_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioral latch; fb_mode 1 = q stuck low, 2 = q and q_bar both high.
  initial lq = 1'b0;
  always @(s or r) begin
    if (s) lq = 1'b1;
    else if (r) lq = 1'b0;
  end
  assign q_fb     = (fb_mode == 0) ? lq  : (fb_mode == 2);
  assign q_bar_fb = (fb_mode == 0) ? ~lq : 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) check("s_r_overlap", 32'(s & r), 32'd0);
  end

  // Issues one command at the next edge (edge 0) and checks cycles 1..6; returns mid-cycle 6.
  task automatic run_cmd(input string ph, input logic is_set, input logic exp_fault,
                         input logic exp_sq, input int poke);
    set_req = is_set;
    clr_req = ~is_set;
    @(posedge clk); #1;
    set_req = 1'b0;
    clr_req = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
        set_req = 1'b0;
        clr_req = 1'b0;
      end
      @(negedge clk);
      check({ph, ".s"},     32'(s),         32'(is_set && c <= 2));
      check({ph, ".r"},     32'(r),         32'(!is_set && c <= 2));
      check({ph, ".ready"}, 32'(cmd_ready), 32'(c == 6));
      check({ph, ".done"},  32'(done),      32'(c == 6));
      check({ph, ".fault"}, 32'(fault),     32'(c == 6 && exp_fault));
      if (c == 6) check({ph, ".state_q"}, 32'(state_q), 32'(exp_sq));
      if (c == poke) begin
        set_req = ~is_set;
        clr_req = is_set;
      end
    end
  endtask

  initial begin
    int n;
    int op;
    logic exp_sq;

    total   = 0;
    bad     = 0;
    fb_mode = 0;
    set_req = 1'b0;
    clr_req = 1'b0;
    rst_n   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.s",       32'(s),         32'd0);
    check("rst.r",       32'(r),         32'd0);
    check("rst.done",    32'(done),      32'd0);
    check("rst.fault",   32'(fault),     32'd0);
    check("rst.illegal", 32'(illegal),   32'd0);
    check("rst.state_q", 32'(state_q),   32'd0);
    check("rst.ready",   32'(cmd_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd("set", 1'b1, 1'b0, 1'b1, 0);
    run_cmd("clr", 1'b0, 1'b0, 1'b0, 0);

    set_req = 1'b1;
    clr_req = 1'b1;
    @(posedge clk); #1;
    set_req = 1'b0;
    clr_req = 1'b0;
    @(negedge clk);
    check("conf.illegal", 32'(illegal),   32'd1);
    check("conf.s",       32'(s),         32'd0);
    check("conf.r",       32'(r),         32'd0);
    check("conf.ready",   32'(cmd_ready), 32'd1);
    check("conf.done",    32'(done),      32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("conf.illegal_drop", 32'(illegal),   32'd0);
      check("conf.no_done",      32'(done),      32'd0);
      check("conf.ready_hold",   32'(cmd_ready), 32'd1);
    end

    fb_mode = 1;
    run_cmd("stuck", 1'b1, 1'b1, 1'b0, 0);
    fb_mode = 0;
    run_cmd("poke", 1'b1, 1'b0, 1'b1, 1);
    fb_mode = 2;
    run_cmd("both1", 1'b0, 1'b1, 1'b1, 0);
    fb_mode = 0;
    run_cmd("b2b_clr", 1'b0, 1'b0, 1'b0, 0);
    run_cmd("b2b_set", 1'b1, 1'b0, 1'b1, 0);

    set_req = 1'b1;
    @(posedge clk); #1;
    set_req = 1'b0;
    @(negedge clk);
    check("mid.s_before", 32'(s), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid.s",       32'(s),         32'd0);
    check("mid.r",       32'(r),         32'd0);
    check("mid.ready",   32'(cmd_ready), 32'd1);
    check("mid.state_q", 32'(state_q),   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("mid.no_done", 32'(done), 32'd0);
      check("mid.idle_s",  32'(s),    32'd0);
    end
    run_cmd("after_rst", 1'b1, 1'b0, 1'b1, 0);

    exp_sq = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      op = int'($urandom_range(0, 3));
      set_req = (op == 0 || op == 2);
      clr_req = (op == 1 || op == 2);
      @(posedge clk); #1;
      set_req = 1'b0;
      clr_req = 1'b0;
      if (op == 2) begin
        @(negedge clk);
        check("rnd.illegal", 32'(illegal), 32'd1);
      end else if (op == 3) begin
        @(negedge clk);
        check("rnd.idle_done", 32'(done), 32'd0);
      end else begin
        exp_sq = (op == 0);
        n = 0;
        while (n < 20) begin
          @(negedge clk);
          n++;
          if (done) break;
          set_req = 1'($urandom_range(0, 1));
          clr_req = 1'($urandom_range(0, 1));
        end
        set_req = 1'b0;
        clr_req = 1'b0;
        if (!done) begin
          check("rnd.timeout", 32'd0, 32'd1);
        end else begin
          check("rnd.latency", 32'(n),       32'd6);
          check("rnd.fault",   32'(fault),   32'd0);
          check("rnd.state_q", 32'(state_q), 32'(exp_sq));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
